if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS core. Owns the program counter, drives a req/ack instruction-memory port, absorbs multi-cycle memory latency and branch redirects, and presents `{PC+4, Instruction}` to the downstream IF/ID pipeline register, which captures on every cycle it is not frozen. Bubbles are presented as the all-zero NOP with PC 0, the same values the IF/ID register loads on flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `freeze` in 1: hazard stall, the same signal that freezes the IF/ID register.
- `branch_taken` in 1: redirect request from the branch-resolution stage.
- `branch_addr` in 32: redirect target; bits [1:0] ignored (forced to 0).
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch word address, equal to `pc_reg`.
- `imem_ack` in 1: memory completion, valid only while `imem_req` is 1.
- `imem_rdata` in 32: instruction word, valid when `imem_ack` is 1.
- `PC` out 32: PC+4 of the delivered instruction, or 0 for a bubble.
- `Instruction` out 32: delivered instruction, or 32'h0 (NOP).

## Operation
- State: `pc_reg` (32), `ibuf` (32), `redir_addr` (32), FSM in {FETCH, HOLD, DRAIN}.
- Memory rule: once `imem_req` is raised, `imem_req` and `imem_addr` stay stable until the `imem_ack` cycle. A request is never withdrawn.
- FETCH: `imem_req`=1.
  - `branch_taken`: bubble out. If `imem_ack`, set `pc_reg`←`branch_addr` and stay in FETCH. Otherwise set `redir_addr`←`branch_addr` and go to DRAIN.
  - `imem_ack` & !`freeze`: deliver `imem_rdata` combinationally with `PC`=`pc_reg`+4, then `pc_reg`←`pc_reg`+4.
  - `imem_ack` & `freeze`: `ibuf`←`imem_rdata`, go to HOLD, bubble out.
  - No ack: bubble out.
- HOLD: `imem_req`=0; `Instruction`=`ibuf`, `PC`=`pc_reg`+4.
  - `branch_taken`: discard `ibuf`, `pc_reg`←`branch_addr`, go to FETCH.
  - !`freeze`: the delivery is consumed, `pc_reg`←`pc_reg`+4, go to FETCH.
- DRAIN: `imem_req`=1 at the stale address; bubble out.
  - On `imem_ack`: data dropped, `pc_reg`←`redir_addr`, go to FETCH.
  - A new `branch_taken` while in DRAIN overwrites `redir_addr`. A new `branch_taken` in the ack cycle wins over the stored `redir_addr`.
- Priority: `branch_taken` > `freeze`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset (async assert, sync release): `pc_reg`=`RESET_PC`, state=FETCH, `ibuf`=0, `redir_addr`=0. Outputs during reset: `imem_req`=0, `PC`=0, `Instruction`=0.
- `imem_req` rises in the first cycle after reset release.
- A reset asserted mid-request abandons the request. The memory must tolerate `imem_req` dropping without ack.
- Zero-wait memory (ack in the request cycle): one instruction per cycle; fetch-to-output latency 0 cycles (combinational), one cycle into IF/ID.
- N-wait memory: N bubble cycles per instruction.
- Redirect penalty: 0 extra cycles if `imem_ack` coincides with `branch_taken`, otherwise the remaining wait of the outstanding request.
- `PC`/`Instruction` are combinational from state and inputs; there is no combinational path from `freeze` to `imem_req`.

## Configuration
- `IF_STAGE_PERF_EN` defined:
  - Adds outputs `perf_fetched` (32), incremented on each delivered and consumed instruction, and `perf_wait` (32), incremented on each cycle with `imem_req`=1 and `imem_ack`=0.
  - Both counters reset to 0 and wrap at 2^32.
- Not defined: both ports and both counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `mips_pkg`:
  - `NOP_INSTR`=32'h0 and `WORD_BYTES`=4.
  - `if_state_t` enum {FETCH, HOLD, DRAIN}.
  - Default `RESET_PC`.
- One sub-module, `if_perf_cnt`, holds both counters and is instantiated only under `IF_STAGE_PERF_EN`. All other logic is flat in `if_stage`.

## Test plan
- Reset release, zero-wait memory returning addr+0x100: `imem_addr` reads 0, 4, 8 on consecutive cycles; `PC` reads 4, 8, 12; `Instruction` reads 0x100, 0x104, 0x108.
- 2-wait memory: each instruction preceded by 2 bubbles (`PC`=0, `Instruction`=0); `imem_addr` stays stable across the wait cycles.
- `freeze` high on the ack cycle at `pc_reg`=0x10 for 3 cycles: HOLD presents `ibuf`, `PC`=0x14, and `imem_req`=0 throughout; the next request after release is at 0x14.
- `branch_taken` to 0x40 one cycle into a 3-wait fetch at 0x8: DRAIN holds `imem_addr`=0x8 until ack, data dropped; the next `imem_addr` is 0x40. A second branch to 0x80 during DRAIN makes the next address 0x80.
- `branch_taken`=1 with `branch_addr`=0x23 coinciding with ack: bubble out; next `imem_addr`=0x20. Separately, a fetch at 0xFFFF_FFFC delivered with `PC`=0.
- `rst` asserted mid-wait: all outputs 0 asynchronously; after release, fetch restarts at `RESET_PC`. With `IF_STAGE_PERF_EN`, `perf_fetched` and `perf_wait` read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: NOP encoding, word size, fetch FSM states
// and the default reset PC.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES       = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } if_state_t;

   // Fetch addresses are always word aligned; the low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory req/ack port. The fetch stage is the master; the
// request and address stay stable until the ack cycle.
interface if_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/if_perf_cnt.sv
// Fetch performance counters: delivered-and-consumed instructions and
// memory wait cycles. Both wrap at 2^32.
module if_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_fetched,
   input  logic        inc_wait,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_wait
);

   logic [1:0]  inc;
   logic [31:0] cnt_reg [2];

   assign inc = {inc_wait, inc_fetched};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_reg[gi] <= '0;
            end else if (inc[gi]) begin
               cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
            end
         end
      end
   endgenerate

   assign perf_fetched = cnt_reg[0];
   assign perf_wait    = cnt_reg[1];

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives the req/ack imem port and
// absorbs wait states, freezes and redirects. Define IF_STAGE_PERF_EN for counters.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   if_stage_if.master  imem,
   output logic [31:0] PC,
   output logic [31:0] Instruction
`ifdef IF_STAGE_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_wait
`endif
);

   if_state_t   state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] ibuf_reg, ibuf_next;
   logic [31:0] redir_addr_reg, redir_addr_next;
   logic        req_int;
   logic [31:0] pc_out, instr_out;
   logic [31:0] branch_tgt;
   logic [31:0] pc_plus4;

   assign branch_tgt = word_align(branch_addr);
   assign pc_plus4   = pc_reg + WORD_BYTES;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= FETCH;
         pc_reg         <= RESET_PC;
         ibuf_reg       <= NOP_INSTR;
         redir_addr_reg <= '0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         ibuf_reg       <= ibuf_next;
         redir_addr_reg <= redir_addr_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      ibuf_next       = ibuf_reg;
      redir_addr_next = redir_addr_reg;
      req_int         = 1'b0;
      pc_out          = '0;
      instr_out       = NOP_INSTR;
      case (state_reg)
         FETCH: begin
            req_int = 1'b1;
            if (branch_taken) begin
               // An outstanding request cannot be withdrawn, so drain it first.
               if (imem.imem_ack) begin
                  pc_next = branch_tgt;
               end else begin
                  redir_addr_next = branch_tgt;
                  state_next      = DRAIN;
               end
            end else if (imem.imem_ack && !freeze) begin
               instr_out = imem.imem_rdata;
               pc_out    = pc_plus4;
               pc_next   = pc_plus4;
            end else if (imem.imem_ack) begin
               ibuf_next  = imem.imem_rdata;
               state_next = HOLD;
            end
         end
         HOLD: begin
            instr_out = ibuf_reg;
            pc_out    = pc_plus4;
            if (branch_taken) begin
               pc_next    = branch_tgt;
               state_next = FETCH;
            end else if (!freeze) begin
               pc_next    = pc_plus4;
               state_next = FETCH;
            end
         end
         DRAIN: begin
            req_int = 1'b1;
            if (imem.imem_ack) begin
               pc_next    = branch_taken ? branch_tgt : redir_addr_reg;
               state_next = FETCH;
            end else if (branch_taken) begin
               redir_addr_next = branch_tgt;
            end
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   // Reset forces the fetch outputs idle immediately, abandoning any request.
   assign imem.imem_req  = rst & req_int;
   assign imem.imem_addr = pc_reg;
   assign PC             = rst ? pc_out : 32'd0;
   assign Instruction    = rst ? instr_out : NOP_INSTR;

`ifdef IF_STAGE_PERF_EN
   logic inc_fetched;
   logic inc_wait;

   assign inc_fetched = !branch_taken && !freeze &&
                        ((state_reg == FETCH && imem.imem_ack) || state_reg == HOLD);
   assign inc_wait    = imem.imem_req && !imem.imem_ack;

   if_perf_cnt u_perf (
      .clk          (clk),
      .rst          (rst),
      .inc_fetched  (inc_fetched),
      .inc_wait     (inc_wait),
      .perf_fetched (perf_fetched),
      .perf_wait    (perf_wait)
   );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// against a transaction-level fetch model with a variable-latency memory.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] PC;
   logic [31:0] Instruction;
   int          wait_n;
   int          cnt;
   int          tests_run;
   int          tests_failed;
`ifdef IF_STAGE_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_wait;
`endif

   if_stage_if bus ();

   if_stage #(.RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem         (bus),
      .PC           (PC),
      .Instruction  (Instruction)
`ifdef IF_STAGE_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_wait    (perf_wait)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: acks after wait_n cycles of request, returns addr + 0x100.
   assign bus.imem_ack   = bus.imem_req && (cnt >= wait_n);
   assign bus.imem_rdata = bus.imem_addr + 32'h100;

   always @(posedge clk) begin
      if (bus.imem_req && !bus.imem_ack) cnt <= cnt + 1;
      else cnt <= 0;
   end

   task automatic apply_reset();
      rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; wait_n = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; wait_n = 0;
      @(negedge clk); #1;
      tests_run += 3;
      if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
      if (PC !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got=%h exp=0", PC); end
      if (Instruction !== 32'h0) begin tests_failed++; $display("FAIL reset_ins got=%h exp=0", Instruction); end
      @(negedge clk); rst = 1'b1; #1;
      tests_run += 2;
      if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL release_req got=%b exp=1", bus.imem_req); end
      if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL release_addr got=%h exp=0", bus.imem_addr); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_zero_wait();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run += 3;
         if (bus.imem_addr !== 32'(4 * i)) begin tests_failed++; $display("FAIL zw_addr i=%0d got=%h exp=%h", i, bus.imem_addr, 4 * i); end
         if (PC !== 32'(4 * i + 4)) begin tests_failed++; $display("FAIL zw_pc i=%0d got=%h exp=%h", i, PC, 4 * i + 4); end
         if (Instruction !== 32'(32'h100 + 4 * i)) begin tests_failed++; $display("FAIL zw_ins i=%0d got=%h exp=%h", i, Instruction, 32'h100 + 4 * i); end
         @(negedge clk);
      end
      $display("[TB] test_zero_wait done");
   endtask

   task automatic test_wait2();
      logic [31:0] ep, ei;
      apply_reset();
      wait_n = 2;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 3; c++) begin
            #1;
            ep = (c == 2) ? 32'(4 * k + 4) : 32'h0;
            ei = (c == 2) ? 32'(32'h100 + 4 * k) : 32'h0;
            tests_run += 3;
            if (bus.imem_addr !== 32'(4 * k)) begin tests_failed++; $display("FAIL w2_addr k=%0d c=%0d got=%h exp=%h", k, c, bus.imem_addr, 4 * k); end
            if (PC !== ep) begin tests_failed++; $display("FAIL w2_pc k=%0d c=%0d got=%h exp=%h", k, c, PC, ep); end
            if (Instruction !== ei) begin tests_failed++; $display("FAIL w2_ins k=%0d c=%0d got=%h exp=%h", k, c, Instruction, ei); end
            @(negedge clk);
         end
      end
      $display("[TB] test_wait2 done");
   endtask

   task automatic test_freeze();
      apply_reset();
      for (int c = 0; c < 9; c++) begin
         freeze = (c >= 4 && c <= 6);
         #1;
         if (c == 4) begin
            tests_run += 2;
            if (bus.imem_addr !== 32'h10) begin tests_failed++; $display("FAIL frz_addr got=%h exp=10", bus.imem_addr); end
            if (Instruction !== 32'h0) begin tests_failed++; $display("FAIL frz_bubble got=%h exp=0", Instruction); end
         end else if (c >= 5 && c <= 7) begin
            tests_run += 3;
            if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL hold_req c=%0d got=%b exp=0", c, bus.imem_req); end
            if (PC !== 32'h14) begin tests_failed++; $display("FAIL hold_pc c=%0d got=%h exp=14", c, PC); end
            if (Instruction !== 32'h110) begin tests_failed++; $display("FAIL hold_ins c=%0d got=%h exp=110", c, Instruction); end
         end else if (c == 8) begin
            tests_run += 2;
            if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL unfrz_req got=%b exp=1", bus.imem_req); end
            if (bus.imem_addr !== 32'h14) begin tests_failed++; $display("FAIL unfrz_addr got=%h exp=14", bus.imem_addr); end
         end
         @(negedge clk);
      end
      freeze = 1'b0;
      $display("[TB] test_freeze done");
   endtask

   // mode 0: single redirect; 1: second redirect during drain; 2: redirect in ack cycle
   task automatic test_branch_drain(input int mode);
      logic [31:0] exp_next;
      exp_next = (mode == 0) ? 32'h40 : (mode == 1) ? 32'h80 : 32'hC0;
      apply_reset();
      for (int c = 0; c < 7; c++) begin
         wait_n       = (c >= 2) ? 3 : 0;
         branch_taken = (c == 3) || (mode == 1 && c == 4) || (mode == 2 && c == 5);
         branch_addr  = (c == 3) ? 32'h40 : (c == 4) ? 32'h80 : 32'hC1;
         #1;
         if (c >= 3 && c <= 5) begin
            tests_run += 3;
            if (bus.imem_addr !== 32'h8) begin tests_failed++; $display("FAIL drain_addr m=%0d c=%0d got=%h exp=8", mode, c, bus.imem_addr); end
            if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL drain_req m=%0d c=%0d got=%b exp=1", mode, c, bus.imem_req); end
            if (Instruction !== 32'h0 || PC !== 32'h0) begin tests_failed++; $display("FAIL drain_bubble m=%0d c=%0d got=%h/%h exp=0/0", mode, c, PC, Instruction); end
         end else if (c == 6) begin
            tests_run++;
            if (bus.imem_addr !== exp_next) begin tests_failed++; $display("FAIL redir_addr m=%0d got=%h exp=%h", mode, bus.imem_addr, exp_next); end
         end
         @(negedge clk);
      end
      branch_taken = 1'b0; wait_n = 0;
      $display("[TB] test_branch_drain mode=%0d done", mode);
   endtask

   task automatic test_branch_ack();
      apply_reset();
      branch_taken = 1'b1; branch_addr = 32'h23; #1;
      tests_run += 2;
      if (bus.imem_ack !== 1'b1 || Instruction !== 32'h0) begin tests_failed++; $display("FAIL brack_bubble got=%h exp=0", Instruction); end
      if (PC !== 32'h0) begin tests_failed++; $display("FAIL brack_pc got=%h exp=0", PC); end
      @(negedge clk); branch_taken = 1'b0; #1;
      tests_run += 2;
      if (bus.imem_addr !== 32'h20) begin tests_failed++; $display("FAIL brack_addr got=%h exp=20", bus.imem_addr); end
      if (Instruction !== 32'h120 || PC !== 32'h24) begin tests_failed++; $display("FAIL brack_deliver got=%h/%h exp=24/120", PC, Instruction); end
      @(negedge clk); branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
      @(negedge clk); branch_taken = 1'b0; #1;
      tests_run += 2;
      if (bus.imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr got=%h exp=fffffffc", bus.imem_addr); end
      if (PC !== 32'h0 || Instruction !== 32'hFC) begin tests_failed++; $display("FAIL wrap_pc got=%h/%h exp=0/fc", PC, Instruction); end
      @(negedge clk); #1;
      tests_run++;
      if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_next got=%h exp=0", bus.imem_addr); end
      $display("[TB] test_branch_ack done");
   endtask

   task automatic test_reset_midwait();
      apply_reset();
      repeat (2) @(negedge clk);
      wait_n = 3;
      @(negedge clk); #3;
      rst = 1'b0; #1;
      tests_run += 3;
      if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL mid_req got=%b exp=0", bus.imem_req); end
      if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL mid_addr got=%h exp=0", bus.imem_addr); end
      if (PC !== 32'h0 || Instruction !== 32'h0) begin tests_failed++; $display("FAIL mid_out got=%h/%h exp=0/0", PC, Instruction); end
`ifdef IF_STAGE_PERF_EN
      tests_run++;
      if (perf_fetched !== 32'h0 || perf_wait !== 32'h0) begin tests_failed++; $display("FAIL mid_perf got=%h/%h exp=0/0", perf_fetched, perf_wait); end
`endif
      @(negedge clk); @(negedge clk); rst = 1'b1; wait_n = 0; #1;
      tests_run += 2;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL restart_addr got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
      if (Instruction !== 32'h100) begin tests_failed++; $display("FAIL restart_ins got=%h exp=100", Instruction); end
      $display("[TB] test_reset_midwait done");
   endtask

   // Model: a PC, at most one held (frozen) instruction and at most one
   // pending redirect target waiting for the outstanding request to finish.
   task automatic test_random();
      logic [31:0] m_pc, tgt, exp_pc, exp_ins, prev_addr;
      logic        exp_req, prev_pending;
      logic [31:0] held_q[$];
      logic [31:0] redir_q[$];
      int          errs0;
      errs0 = tests_failed;
      apply_reset();
      m_pc = 32'h0; prev_pending = 1'b0; prev_addr = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         freeze       = ($urandom_range(0, 3) == 0);
         branch_taken = ($urandom_range(0, 7) == 0);
         branch_addr  = $urandom;
         wait_n       = $urandom_range(0, 3);
         #1;
         tgt = branch_addr & ~32'd3;
         exp_req = (held_q.size() == 0);
         exp_pc = 32'h0; exp_ins = 32'h0;
         tests_run += 5;
         if (bus.imem_addr !== m_pc) begin tests_failed++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, m_pc); end
         if (bus.imem_req !== exp_req) begin tests_failed++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, bus.imem_req, exp_req); end
         if (prev_pending && (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr)) begin
            tests_failed++; $display("FAIL rnd_stable cyc=%0d got=%b/%h exp=1/%h", cyc, bus.imem_req, bus.imem_addr, prev_addr);
         end
         if (held_q.size() != 0) begin
            exp_pc = m_pc + 4; exp_ins = held_q[0];
            if (branch_taken) begin m_pc = tgt; held_q.delete(); end
            else if (!freeze) begin m_pc = m_pc + 4; held_q.delete(); end
         end else if (redir_q.size() != 0) begin
            if (bus.imem_ack) begin m_pc = branch_taken ? tgt : redir_q[0]; redir_q.delete(); end
            else if (branch_taken) redir_q[0] = tgt;
         end else if (branch_taken) begin
            if (bus.imem_ack) m_pc = tgt;
            else redir_q.push_back(tgt);
         end else if (bus.imem_ack && !freeze) begin
            exp_pc = m_pc + 4; exp_ins = m_pc + 32'h100; m_pc = m_pc + 4;
         end else if (bus.imem_ack) begin
            held_q.push_back(m_pc + 32'h100);
         end
         if (PC !== exp_pc) begin tests_failed++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, PC, exp_pc); end
         if (Instruction !== exp_ins) begin tests_failed++; $display("FAIL rnd_ins cyc=%0d got=%h exp=%h", cyc, Instruction, exp_ins); end
         prev_pending = bus.imem_req && !bus.imem_ack;
         prev_addr    = bus.imem_addr;
         @(negedge clk);
      end
      freeze = 1'b0; branch_taken = 1'b0; wait_n = 0;
      $display("[TB] test_random done, %0d new failures", tests_failed - errs0);
   endtask

   initial begin
      tests_run = 0; tests_failed = 0; cnt = 0;
      test_reset();
      test_zero_wait();
      test_wait2();
      test_freeze();
      test_branch_drain(0);
      test_branch_drain(1);
      test_branch_drain(2);
      test_branch_ack();
      test_reset_midwait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
